// File: rtl/csr_stream_encoder_pkg.sv
// csr_stream_encoder_pkg: FSM states, widths and word-packing helpers for the CSR stream encoder
package csr_stream_encoder_pkg;
    typedef enum logic [2:0] {IDLE, ENCODE, PTRS, TRAIL, DONE} state_t;
    localparam int NNZ_W = 14;
    localparam int ROW_ADDR_W = 10;
    localparam int COL_W = 14;
    localparam int COL_PAD_W = 32 - COL_W;
    localparam int IDX_PAD_W = 32 - ROW_ADDR_W;
    function automatic logic [31:0] pack_col(input logic [COL_W-1:0] c);
        return {{COL_PAD_W{1'b0}}, c};
    endfunction
    function automatic logic [31:0] pack_idx(input logic [ROW_ADDR_W-1:0] i);
        return {{IDX_PAD_W{1'b0}}, i};
    endfunction
endpackage

// File: rtl/csr_stream_encoder_if.sv
// csr_stream_encoder_if: dense input and CSR pair output handshakes
interface csr_stream_encoder_if;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] tx_word1;
    logic [31:0] tx_word2;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    modport master (output din, din_valid, tx_ready, input din_ready, tx_word1, tx_word2, tx_valid, tx_last);
    modport slave (input din, din_valid, tx_ready, output din_ready, tx_word1, tx_word2, tx_valid, tx_last);
endinterface

// File: rtl/csr_stream_encoder_tx_reg.sv
// csr_tx_reg: single output holding register with valid/ready handshake
module csr_tx_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] next_word1,
    input  logic [31:0] next_word2,
    input  logic        next_last,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [31:0] tx_word1,
    output logic [31:0] tx_word2,
    output logic        tx_last
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_valid <= 1'b0;
            tx_word1 <= '0;
            tx_word2 <= '0;
            tx_last  <= 1'b0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_word1 <= next_word1;
            tx_word2 <= next_word2;
            tx_last  <= next_last;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/csr_stream_encoder.sv
// csr_stream_encoder: dense row-major matrix to CSR pair stream; CSR_MAXROW_EN adds max_row_nnz output
module csr_stream_encoder #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int NNZ_W = csr_stream_encoder_pkg::NNZ_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    csr_stream_encoder_if.slave bus,
    output logic busy,
    output logic done,
    output logic ovf
`ifdef CSR_MAXROW_EN
    ,
    output logic [NNZ_W-1:0] max_row_nnz
`endif
);
    import csr_stream_encoder_pkg::*;
    localparam int PW = $clog2(ROWS + 1);
    localparam int IDX_W = ROW_ADDR_W + 1;
    state_t state, nxt;
    logic [COL_W-1:0] col;
    logic [ROW_ADDR_W-1:0] row;
    logic [IDX_W-1:0] idx;
    logic [NNZ_W-1:0] nnz, nnz_n;
    logic [NNZ_W-1:0] ptr [ROWS+1];
    logic free, accept, nz, sat, inc, wrap, last_el, ptr_load, load, last;
    logic [31:0] word1, word2;

    assign free      = !bus.tx_valid || bus.tx_ready;
    assign bus.din_ready = state == ENCODE && free;
    assign accept    = bus.din_valid && bus.din_ready;
    assign nz        = bus.din != '0;
    assign sat       = &nnz;
    assign inc       = accept && nz && !sat;
    assign nnz_n     = nnz + NNZ_W'(inc);
    assign wrap      = col == COL_W'(COLS - 1);
    assign last_el   = wrap && row == ROW_ADDR_W'(ROWS - 1);
    assign ptr_load  = state == PTRS && free && idx != IDX_W'(ROWS + 1);
    assign busy      = state inside {ENCODE, PTRS, TRAIL};
    assign done      = state == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt   = state;
        load  = 1'b0;
        word1 = '0;
        word2 = '0;
        last  = 1'b0;
        case (state)
            IDLE: nxt = start ? ENCODE : IDLE;
            ENCODE: begin
                load  = inc;
                word1 = bus.din;
                word2 = pack_col(col);
                nxt   = accept && last_el ? PTRS : ENCODE;
            end
            PTRS: begin
                load  = free;
                word1 = ptr_load ? pack_idx(idx[ROW_ADDR_W-1:0]) : 32'(nnz);
                word2 = ptr_load ? 32'(ptr[PW'(idx)]) : 32'(ROWS);
                last  = !ptr_load;
                nxt   = free && !ptr_load ? TRAIL : PTRS;
            end
            TRAIL: nxt = bus.tx_valid && bus.tx_ready ? DONE : TRAIL;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            idx <= '0;
            nnz <= '0;
            ovf <= 1'b0;
            for (int i = 0; i <= ROWS; i++) ptr[i] <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
            idx <= '0;
            nnz <= '0;
            ovf <= 1'b0;
        end else begin
            if (accept) begin
                nnz <= nnz_n;
                ovf <= ovf || (nz && sat);
                col <= wrap ? '0 : col + COL_W'(1);
                if (wrap) begin
                    row <= row + ROW_ADDR_W'(1);
                    ptr[PW'(row + ROW_ADDR_W'(1))] <= nnz_n;
                end
            end
            if (ptr_load) idx <= idx + IDX_W'(1);
        end
    end

`ifdef CSR_MAXROW_EN
    logic [NNZ_W-1:0] row_nnz;
    assign row_nnz = nnz_n - ptr[PW'(row)];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) max_row_nnz <= '0;
        else if (state == IDLE && start) max_row_nnz <= '0;
        else if (accept && wrap && row_nnz > max_row_nnz) max_row_nnz <= row_nnz;
    end
`endif

    csr_tx_reg u_tx (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .next_word1 (word1),
        .next_word2 (word2),
        .next_last  (last),
        .tx_ready   (bus.tx_ready),
        .tx_valid   (bus.tx_valid),
        .tx_word1   (bus.tx_word1),
        .tx_word2   (bus.tx_word2),
        .tx_last    (bus.tx_last)
    );
endmodule

// File: tb/tb_csr_stream_encoder.sv
// tb_csr_stream_encoder: directed and random CSR encoding checked against a matrix-level reference model
module tb_csr_stream_encoder;
    logic clk, reset, start, din_valid, tx_ready, sel;
    logic [31:0] din;
    logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    int checks = 0;
    int errors = 0;
    int unsigned mat[$];
    logic [64:0] exp_q[$];
    bit exp_ovf;

    csr_stream_encoder_if ia ();
    csr_stream_encoder_if ib ();
    assign ia.din = din;
    assign ia.din_valid = din_valid;
    assign ia.tx_ready = tx_ready;
    assign ib.din = din;
    assign ib.din_valid = din_valid;
    assign ib.tx_ready = tx_ready;

`ifdef CSR_MAXROW_EN
    logic [13:0] max_a;
    logic [1:0] max_b;
    logic [13:0] o_max;
    assign o_max = sel ? 14'(max_b) : max_a;
`endif

    csr_stream_encoder #(.ROWS(2), .COLS(3), .NNZ_W(14)) dut_a (
        .clk(clk), .reset(reset), .start(start), .bus(ia.slave),
        .busy(busy_a), .done(done_a), .ovf(ovf_a)
`ifdef CSR_MAXROW_EN
        , .max_row_nnz(max_a)
`endif
    );

    csr_stream_encoder #(.ROWS(1), .COLS(5), .NNZ_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .bus(ib.slave),
        .busy(busy_b), .done(done_b), .ovf(ovf_b)
`ifdef CSR_MAXROW_EN
        , .max_row_nnz(max_b)
`endif
    );

    logic o_valid, o_last, o_dready, o_busy, o_done, o_ovf;
    logic [31:0] o_w1, o_w2;
    logic [64:0] o_pair;
    assign o_valid  = sel ? ib.tx_valid : ia.tx_valid;
    assign o_last   = sel ? ib.tx_last : ia.tx_last;
    assign o_w1     = sel ? ib.tx_word1 : ia.tx_word1;
    assign o_w2     = sel ? ib.tx_word2 : ia.tx_word2;
    assign o_dready = sel ? ib.din_ready : ia.din_ready;
    assign o_busy   = sel ? busy_b : busy_a;
    assign o_done   = sel ? done_b : done_a;
    assign o_ovf    = sel ? ovf_b : ovf_a;
    assign o_pair   = {o_last, o_w1, o_w2};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [64:0] o, input logic [64:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chkb(input string tag, input logic o, input logic e);
        chk(tag, 65'(o), 65'(e));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_words"}, {1'b0, o_w1, o_w2}, 65'h0);
        chk({tag, "_flags"}, 65'({o_valid, o_last, o_dready, o_busy, o_done, o_ovf}), 65'h0);
    endtask

    task automatic run(input bit s, input int rmode, input bit rnd);
        int rows, cols, nmax, n, k, cyc, nnz;
        int ptrs[$];
        bit got_done, stall;
        logic [64:0] held, e;
`ifdef CSR_MAXROW_EN
        int e_max = 0;
`endif
        rows = s ? 1 : 2;
        cols = s ? 5 : 3;
        nmax = s ? 3 : 16383;
        n = rows * cols;
        exp_q.delete();
        ptrs.delete();
        ptrs.push_back(0);
        exp_ovf = 0;
        nnz = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (mat[r * cols + c] != 0) begin
                    if (nnz < nmax) begin
                        exp_q.push_back({1'b0, mat[r * cols + c], 32'(c)});
                        nnz++;
                    end else exp_ovf = 1;
                end
            end
            ptrs.push_back(nnz);
`ifdef CSR_MAXROW_EN
            if (ptrs[r + 1] - ptrs[r] > e_max) e_max = ptrs[r + 1] - ptrs[r];
`endif
        end
        for (int i = 0; i <= rows; i++) exp_q.push_back({1'b0, 32'(i), 32'(ptrs[i])});
        exp_q.push_back({1'b1, 32'(nnz), 32'(rows)});
        if (s != sel) begin
            @(negedge clk);
            reset = 0;
            @(negedge clk);
            reset = 1;
        end
        sel = s;
        @(negedge clk);
        start = 1;
        k = 0;
        cyc = 0;
        got_done = 0;
        stall = 0;
        held = '0;
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = rnd && $urandom_range(0, 7) == 0;
            tx_ready = (rmode == 0) || (rmode == 1 && (cyc % 4 == 0 || cyc % 4 == 1))
                       || (rmode == 2 && $urandom_range(0, 1) == 1);
            din_valid = k < n && (!rnd || $urandom_range(0, 3) != 0);
            din = k < n ? mat[k] : $urandom;
            #1;
            if (stall) begin
                chkb("hold_valid", o_valid, 1'b1);
                chk("hold_pair", o_pair, held);
            end
            if (k < n && tx_ready) chkb("din_ready_flow", o_dready, 1'b1);
            if (k < n && !tx_ready && o_valid) chkb("din_ready_stall", o_dready, 1'b0);
            chkb("busy", o_busy, !o_done);
            if (o_valid && tx_ready) begin
                e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                chk("pair", o_pair, e);
            end
            stall = o_valid && !tx_ready;
            held = o_pair;
            if (din_valid && o_dready) k++;
            got_done = o_done;
        end
        start = 0;
        chkb("done_seen", got_done, 1'b1);
        chk("pairs_left", 65'(exp_q.size()), 65'h0);
        chkb("ovf", o_ovf, exp_ovf);
`ifdef CSR_MAXROW_EN
        chk("max_row_nnz", 65'(o_max), 65'(e_max));
`endif
        @(negedge clk);
        din_valid = 1;
        tx_ready = 1;
        #1;
        chkb("done_once", o_done, 1'b0);
        chkb("idle_busy", o_busy, 1'b0);
        chkb("idle_din_ready", o_dready, 1'b0);
        chkb("idle_tx_valid", o_valid, 1'b0);
        din_valid = 0;
    endtask

    initial begin
        reset = 0;
        start = 0;
        din = '0;
        din_valid = 0;
        tx_ready = 0;
        sel = 0;
        repeat (2) @(negedge clk);
        #1;
        check_cleared("reset_a");
        sel = 1;
        #1;
        check_cleared("reset_b");
        sel = 0;
        @(negedge clk);
        reset = 1;

        mat = '{5, 0, 7, 0, 0, 9};
        run(0, 0, 0);
        mat = '{0, 0, 0, 0, 0, 0};
        run(0, 0, 0);
        mat = '{5, 0, 7, 0, 0, 9};
        run(0, 1, 0);

        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        tx_ready = 1;
        din_valid = 1;
        din = 5;
        @(negedge clk);
        din = 0;
        @(negedge clk);
        din_valid = 0;
        #1;
        chkb("pre_reset_busy", o_busy, 1'b1);
        reset = 0;
        #1;
        check_cleared("mid_reset");
        @(negedge clk);
        reset = 1;
        run(0, 0, 0);

        mat = '{1, 2, 3, 4, 5};
        run(1, 0, 0);
        mat = '{1, 2, 3, 0, 4, 0};
        run(0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            mat.delete();
            for (int i = 0; i < 6; i++) mat.push_back($urandom_range(0, 1) == 1 ? $urandom : 0);
            run(0, 2, 1);
        end
        for (int t = 0; t < 4; t++) begin
            mat.delete();
            for (int i = 0; i < 5; i++) mat.push_back($urandom_range(0, 1) == 1 ? $urandom : 0);
            run(1, 2, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
